rs_motion_distorter: RTL and testbench
======================================

Name: rs_motion_distorter

Overview:
- Inverse of the rolling-shutter motion corrector. Takes clean (motion-free) points with their per-point rolling-shutter time and the IMU X acceleration, integrates velocity across a frame, and emits the distorted point (px = cx - dx).
- Feeds the corrector's verification and simulation path with synthetic distorted scans.
- Streaming valid/ready in and out, 2-stage pipeline, velocity state held across points of a frame.

Parameters:
- WP, 32, word width of all signed data (points, dt, acceleration, velocity).
- FRAC, 16, fractional bits of the signed fixed-point format (Q(WP-FRAC).FRAC).
- IDXW, 16, width of the per-frame point index.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input point valid.
- in_ready  out  1  block can accept the input point this cycle.
- frame_start  in  1  qualifies the accepted point as first of a frame.
- v_init  in  WP  velocity loaded at frame start.
- cx, cy, cz  in  WP each  clean point.
- dt  in  WP  rolling-shutter time of this point.
- a_x  in  WP  IMU X acceleration for this point.
- out_valid  out  1  distorted point valid.
- out_ready  in  1  downstream accepts.
- px, py, pz  out  WP each  distorted point.
- v_out  out  WP  velocity after this point (v(k+1)).
- point_idx  out  IDXW  index of this point within its frame (0 = frame_start point).

Behaviour:
- Reset (async, rst_n=0): all pipeline valids 0; velocity register 0; index counter 0; out_valid=0; px, py, pz, v_out, point_idx all 0. Deassertion takes effect on the next clk edge.
- Global advance: en = !out_valid || out_ready. in_ready = en. Both stages advance together when en=1; the whole pipe holds when en=0. Accept = in_valid && in_ready.
- Stage 1 (on accept):
  - v_base = frame_start ? v_init : v_reg.
  - dv = (a_x * dt) >>> FRAC, using a full 2*WP product, arithmetic shift (floor), truncated to WP.
  - v_new = v_base + dv, wraps mod 2^WP.
  - v_reg <= v_new.
  - idx = frame_start ? 0 : cnt; cnt <= idx + 1, wraps at 2^IDXW.
  - Register cx, cy, cz, dt, v_new, idx and s1_valid.
- Stage 1 with en=1 and no accept: s1_valid <= 0; v_reg and cnt unchanged.
- Stage 2 (when en=1):
  - dx = (v_new * dt) >>> FRAC, same width rules as dv.
  - px = cx - dx, wraps. py = cy. pz = cz.
  - v_out = v_new. point_idx = idx.
  - out_valid <= s1_valid.
- Latency: 2 cycles from accept to out_valid when out_ready is held high. Throughput: 1 point per cycle.
- Ordering: outputs appear in strict input order. Velocity dependency is satisfied in stage 1, so back-to-back points need no bubble.
- Backpressure: while out_valid && !out_ready, px, py, pz, v_out and point_idx hold stable; in_ready=0; v_reg and cnt do not change.
- frame_start without accept: ignored; no state change.
- Reset mid-operation: in-flight points are discarded; no output after reset until a new accept.
- Overflow is not flagged; arithmetic wraps silently.

Test Plan:
- Frame start, FRAC=16, v_init=0, a_x=65536, dt=32768, cx=131072, cy=5, cz=-7, out_ready=1 -> 2 cycles later: px=114688, py=5, pz=-7, v_out=32768, point_idx=0.
- Second point immediately after, no frame_start, same a_x, dt, cx -> next cycle: v_out=65536, px=98304, point_idx=1. Then a third point with frame_start and v_init=0 -> v_out=32768, point_idx=0.
- Floor rounding: frame_start, v_init=0, a_x=-1, dt=1 -> dv=-1, v_out=-1, dx=-1, px=cx+1.
- Backpressure: stream 4 points with out_ready=0 from cycle 3 for 5 cycles -> in_ready=0 throughout the stall, outputs stable, v_reg frozen; after release all 4 points emerge in order with correct values, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 2 points in flight -> out_valid=0 and all outputs 0 immediately; after release the first accepted point without frame_start uses v=0, idx=0.
- Wrap: cx=0x7FFFFFFF, dx=-1 -> px=0x80000000. cnt at 0xFFFF followed by a non-frame_start point -> point_idx=0.

Source files
------------

// File: rtl/rs_motion_distorter_if.sv
// Stream interface of the rolling-shutter motion distorter: clean point in,
// distorted point plus integrated velocity and frame index out.
interface rs_motion_distorter_if #(
  parameter int WP   = 32,
  parameter int IDXW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic            frame_start;
  logic [WP-1:0]   v_init;
  logic [WP-1:0]   cx;
  logic [WP-1:0]   cy;
  logic [WP-1:0]   cz;
  logic [WP-1:0]   dt;
  logic [WP-1:0]   a_x;
  logic            out_valid;
  logic            out_ready;
  logic [WP-1:0]   px;
  logic [WP-1:0]   py;
  logic [WP-1:0]   pz;
  logic [WP-1:0]   v_out;
  logic [IDXW-1:0] point_idx;

  modport master (
    output in_valid, frame_start, v_init, cx, cy, cz, dt, a_x, out_ready,
    input  in_ready, out_valid, px, py, pz, v_out, point_idx
  );

  modport slave (
    input  in_valid, frame_start, v_init, cx, cy, cz, dt, a_x, out_ready,
    output in_ready, out_valid, px, py, pz, v_out, point_idx
  );
endinterface

// File: rtl/rs_motion_distorter.sv
// Rolling-shutter distorter: integrates X velocity across a frame and emits
// px = cx - v*dt. Two-stage pipeline sharing one global advance enable.
module rs_motion_distorter #(
  parameter int WP   = 32,
  parameter int FRAC = 16,
  parameter int IDXW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rs_motion_distorter_if.slave s_if
);

  // Signed fixed-point multiply: full 2*WP product, floor shift, truncate to WP.
  function automatic logic [WP-1:0] fx_mul(input logic [WP-1:0] a, input logic [WP-1:0] b);
    logic signed [2*WP-1:0] a_ext;
    logic signed [2*WP-1:0] b_ext;
    logic signed [2*WP-1:0] prod;
    a_ext = {{WP{a[WP-1]}}, a};
    b_ext = {{WP{b[WP-1]}}, b};
    prod  = a_ext * b_ext;
    prod  = prod >>> FRAC;
    return prod[WP-1:0];
  endfunction

  logic            w_en;
  logic            w_accept;
  logic [WP-1:0]   w_v_base;
  logic [WP-1:0]   w_v_new;
  logic [IDXW-1:0] w_idx;

  logic [WP-1:0]   r_v;
  logic [IDXW-1:0] r_cnt;
  logic            r_s1_valid;
  logic [WP-1:0]   r_s1_cx;
  logic [WP-1:0]   r_s1_cy;
  logic [WP-1:0]   r_s1_cz;
  logic [WP-1:0]   r_s1_dt;
  logic [WP-1:0]   r_s1_v;
  logic [IDXW-1:0] r_s1_idx;

  logic            r_out_valid;
  logic [WP-1:0]   r_px;
  logic [WP-1:0]   r_py;
  logic [WP-1:0]   r_pz;
  logic [WP-1:0]   r_v_out;
  logic [IDXW-1:0] r_idx;

  assign w_en     = !r_out_valid || s_if.out_ready;
  assign w_accept = s_if.in_valid && w_en;
  assign w_v_base = s_if.frame_start ? s_if.v_init : r_v;
  assign w_v_new  = w_v_base + fx_mul(s_if.a_x, s_if.dt);
  assign w_idx    = s_if.frame_start ? '0 : r_cnt;

  // Velocity is resolved in stage 1 so back-to-back points never stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v        <= '0;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_cx    <= '0;
      r_s1_cy    <= '0;
      r_s1_cz    <= '0;
      r_s1_dt    <= '0;
      r_s1_v     <= '0;
      r_s1_idx   <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_v      <= w_v_new;
        r_cnt    <= w_idx + IDXW'(1);
        r_s1_cx  <= s_if.cx;
        r_s1_cy  <= s_if.cy;
        r_s1_cz  <= s_if.cz;
        r_s1_dt  <= s_if.dt;
        r_s1_v   <= w_v_new;
        r_s1_idx <= w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_pz        <= '0;
      r_v_out     <= '0;
      r_idx       <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_px        <= r_s1_cx - fx_mul(r_s1_v, r_s1_dt);
      r_py        <= r_s1_cy;
      r_pz        <= r_s1_cz;
      r_v_out     <= r_s1_v;
      r_idx       <= r_s1_idx;
    end
  end

  assign s_if.in_ready  = w_en;
  assign s_if.out_valid = r_out_valid;
  assign s_if.px        = r_px;
  assign s_if.py        = r_py;
  assign s_if.pz        = r_pz;
  assign s_if.v_out     = r_v_out;
  assign s_if.point_idx = r_idx;

endmodule

// File: tb/tb_rs_motion_distorter.sv
// Directed bench for rs_motion_distorter: inputs driven and outputs sampled
// on the falling clock edge, expected values computed by hand.
module tb_rs_motion_distorter;
  localparam int WP   = 32;
  localparam int FRAC = 16;
  localparam int IDXW = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rs_motion_distorter_if #(.WP(WP), .IDXW(IDXW)) u_if ();

  rs_motion_distorter #(.WP(WP), .FRAC(FRAC), .IDXW(IDXW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit v, input bit fs, input logic [31:0] vi,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic [31:0] t, input logic [31:0] a);
    u_if.in_valid    = v;
    u_if.frame_start = fs;
    u_if.v_init      = vi;
    u_if.cx          = x;
    u_if.cy          = y;
    u_if.cz          = z;
    u_if.dt          = t;
    u_if.a_x         = a;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [144:0] ev(input logic ov, input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, input logic [31:0] v, input logic [15:0] idx);
    return {ov, x, y, z, v, idx};
  endfunction

  function automatic logic [144:0] obs();
    return {u_if.out_valid, u_if.px, u_if.py, u_if.pz, u_if.v_out, u_if.point_idx};
  endfunction

  task automatic test_reset();
    logic [144:0] got;
    rst_n = 1'b0;
    u_if.out_ready = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", got, ev(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0));
    end
    checks++;
    if (u_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", u_if.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [144:0] got;
    drive(1'b1, 1'b1, 32'd0, 32'd131072, 32'd5, -32'sd7, 32'd32768, 32'd65536);
    @(negedge clk);
    checks++;
    if (u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: out_valid got %b expected 0 one cycle after accept", u_if.out_valid);
    end
    drive(1'b1, 1'b0, 32'd0, 32'd131072, 32'd6, -32'sd8, 32'd32768, 32'd65536);
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b1, 32'd114688, 32'd5, -32'sd7, 32'd32768, 16'd0)) begin
      errors++;
      $display("FAIL basic_first: got %h expected %h", got, ev(1'b1, 32'd114688, 32'd5, -32'sd7, 32'd32768, 16'd0));
    end
    drive(1'b1, 1'b1, 32'd0, 32'd131072, 32'd7, -32'sd9, 32'd32768, 32'd65536);
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b1, 32'd98304, 32'd6, -32'sd8, 32'd65536, 16'd1)) begin
      errors++;
      $display("FAIL basic_second: got %h expected %h", got, ev(1'b1, 32'd98304, 32'd6, -32'sd8, 32'd65536, 16'd1));
    end
    idle();
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b1, 32'd114688, 32'd7, -32'sd9, 32'd32768, 16'd0)) begin
      errors++;
      $display("FAIL basic_new_frame: got %h expected %h", got, ev(1'b1, 32'd114688, 32'd7, -32'sd9, 32'd32768, 16'd0));
    end
    @(negedge clk);
    checks++;
    if (u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid got %b expected 0", u_if.out_valid);
    end
  endtask

  task automatic test_floor();
    logic [144:0] got;
    drive(1'b1, 1'b1, 32'd0, 32'd100, 32'd1, 32'd2, 32'd1, -32'sd1);
    @(negedge clk);
    idle();
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b1, 32'd101, 32'd1, 32'd2, 32'hFFFFFFFF, 16'd0)) begin
      errors++;
      $display("FAIL floor_round: got %h expected %h", got, ev(1'b1, 32'd101, 32'd1, 32'd2, 32'hFFFFFFFF, 16'd0));
    end
  endtask

  task automatic test_wrap_px();
    logic [144:0] got;
    drive(1'b1, 1'b1, 32'd0, 32'h7FFFFFFF, 32'd3, 32'd4, 32'd1, -32'sd1);
    @(negedge clk);
    idle();
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b1, 32'h80000000, 32'd3, 32'd4, 32'hFFFFFFFF, 16'd0)) begin
      errors++;
      $display("FAIL wrap_px: got %h expected %h", got, ev(1'b1, 32'h80000000, 32'd3, 32'd4, 32'hFFFFFFFF, 16'd0));
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [144:0] got;
    logic [144:0] held;
    logic [144:0] exp_v;
    bit holding;
    int p;
    int q;
    int cyc;
    p = 0; q = 0; cyc = 0; holding = 0; held = '0;
    while (q < 4 && cyc < 40) begin
      u_if.out_ready = !(cyc >= 3 && cyc < 8);
      if (p < 4) drive(1'b1, p == 0, 32'd0, 32'd131072, p + 1, -(p + 1), 32'd32768, 32'd65536);
      else idle();
      #1;
      got = obs();
      if (u_if.out_valid && u_if.out_ready) begin
        exp_v = ev(1'b1, 131072 - 16384 * (q + 1), q + 1, -(q + 1), 32768 * (q + 1), 16'(q));
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL bp_point%0d: got %h expected %h", q, got, exp_v);
        end
        q++;
        holding = 0;
      end else if (u_if.out_valid) begin
        checks++;
        if (u_if.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: got %b expected 0 during stall (cycle %0d)", u_if.in_ready, cyc);
        end
        if (holding) begin
          checks++;
          if (got !== held) begin
            errors++;
            $display("FAIL bp_hold: got %h expected %h (cycle %0d)", got, held, cyc);
          end
        end else begin
          held = got;
          holding = 1;
        end
      end
      if (u_if.in_valid && u_if.in_ready) p++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (q != 4) begin
      errors++;
      $display("FAIL bp_timeout: got %0d outputs expected 4", q);
    end
    idle();
    u_if.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: out_valid got %b expected 0", u_if.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [144:0] got;
    drive(1'b1, 1'b1, 32'd327680, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd0, 32'd20, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== ev(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd0)) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h expected all zero", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'd65536000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (u_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_output: out_valid got %b expected 0", u_if.out_valid);
    end
    drive(1'b1, 1'b0, 32'd0, 32'd131072, 32'd3, 32'd4, 32'd32768, 32'd65536);
    @(negedge clk);
    idle();
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== ev(1'b1, 32'd114688, 32'd3, 32'd4, 32'd32768, 16'd0)) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h expected %h", got, ev(1'b1, 32'd114688, 32'd3, 32'd4, 32'd32768, 16'd0));
    end
    @(negedge clk);
  endtask

  task automatic test_idx_wrap();
    int sent;
    int got_n;
    int bad;
    int cyc;
    logic [15:0] last_idx;
    logic [15:0] prev_idx;
    sent = 0; got_n = 0; bad = 0; cyc = 0;
    last_idx = '0; prev_idx = '0;
    u_if.out_ready = 1'b1;
    while (got_n < 65537 && cyc < 70000) begin
      if (sent < 65537) drive(1'b1, sent == 0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      else idle();
      if (u_if.out_valid) begin
        if (u_if.point_idx !== got_n[15:0]) bad++;
        prev_idx = last_idx;
        last_idx = u_if.point_idx;
        got_n++;
      end
      sent++;
      cyc++;
      @(negedge clk);
    end
    idle();
    checks++;
    if (got_n != 65537) begin
      errors++;
      $display("FAIL idx_timeout: got %0d outputs expected 65537", got_n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idx_sequence: got %0d out-of-sequence indices expected 0", bad);
    end
    checks++;
    if (prev_idx !== 16'hFFFF) begin
      errors++;
      $display("FAIL idx_top: got %h expected ffff", prev_idx);
    end
    checks++;
    if (last_idx !== 16'h0000) begin
      errors++;
      $display("FAIL idx_wrap: got %h expected 0000", last_idx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_floor();
    test_wrap_px();
    test_backpressure();
    test_reset_mid();
    test_idx_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
